// File: rtl/uart_pkg.sv
// Shared types and constants for the memory-mapped UART receiver.
// Optional 8E1 parity support is enabled by defining UART_RX_PARITY_EN.
`ifndef XLEN
`define XLEN 32
`endif
`ifndef ADDR_W
`define ADDR_W 32
`endif
`ifndef IO_BASE_ADDR
`define IO_BASE_ADDR 32'h1000_0000
`endif

package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } rx_state_e;

    localparam logic [`ADDR_W-1:0] RXDATA_OFF = `ADDR_W'(3'd0);
    localparam logic [`ADDR_W-1:0] RXSTAT_OFF = `ADDR_W'(3'd4);

    localparam int STAT_VALID   = 0;
    localparam int STAT_OVERRUN = 1;
    localparam int STAT_FRAME   = 2;
    localparam int STAT_PARITY  = 3;

    // Even parity: the parity bit equals the XOR of the data bits.
    function automatic logic even_parity(input logic [7:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Synchronous receive FIFO. A push into a full FIFO is accepted only when a
// pop frees a slot in the same cycle; otherwise the new entry is dropped.
module uart_rx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   DEPTH_C = DEPTH[AW:0];
    localparam logic [AW:0]   CNT_ONE = (AW+1)'(1'b1);
    localparam logic [AW-1:0] PTR_ONE = AW'(1'b1);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [AW:0]      count_r;
    logic             do_push_s;
    logic             do_pop_s;

    assign empty = (count_r == {(AW+1){1'b0}});
    assign full  = (count_r == DEPTH_C);
    assign head  = mem_r[rd_ptr_r];

    // Qualify requests: pops need data, pushes need space or a concurrent pop
    always_comb begin
        do_pop_s  = pop && !empty;
        do_push_s = push && (!full || do_pop_s);
    end

    // Pointer and occupancy bookkeeping
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {(AW+1){1'b0}};
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

    // Entry storage, written on accepted pushes
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r] <= din;
        end
    end

endmodule

// File: rtl/uart_rx_mmio.sv
// Memory-mapped UART receiver: RXDATA pops the FIFO, RXSTAT reports status
// and clears sticky errors on write-1. UART_RX_PARITY_EN selects 8E1 framing.
module uart_rx_mmio
    import uart_pkg::*;
#(
    parameter int                  CLKS_PER_BIT = 434,
    parameter int                  FIFO_DEPTH   = 4,
    parameter logic [`ADDR_W-1:0]  BASE_ADDR    = `IO_BASE_ADDR + 32'h10
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               uart_rx,
    input  logic               mmio_req,
    input  logic               mmio_we,
    input  logic [`ADDR_W-1:0] mmio_addr,
    input  logic [`XLEN-1:0]   mmio_wdata,
    output logic [`XLEN-1:0]   mmio_rdata,
    output logic               rx_irq
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_C   = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_C   = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1'b1);
    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
    localparam logic [`ADDR_W-1:0] RXDATA_ADDR = BASE_ADDR + RXDATA_OFF;
    localparam logic [`ADDR_W-1:0] RXSTAT_ADDR = BASE_ADDR + RXSTAT_OFF;

    rx_state_e     state_r;
    logic [CW-1:0] baud_cnt_r;
    logic [2:0]    bit_idx_r;
    logic [7:0]    shreg_r;
    logic          sync1_r;
    logic          sync2_r;
    logic          hist_r;
    logic          overrun_r;
    logic          frame_err_r;
    logic          par_err_r;
    logic          rx_irq_r;

    logic          stop_tick_s;
    logic          par_ok_s;
    logic          push_s;
    logic          pop_s;
    logic          frame_set_s;
    logic          par_set_s;
    logic          ovr_set_s;
    logic [3:0]    clr_s;
    logic [3:0]    stat_s;
    logic          fifo_full_s;
    logic          fifo_empty_s;
    logic [7:0]    fifo_head_s;
    logic          unused_s;

`ifdef UART_RX_PARITY_EN
    logic          par_bit_r;
`endif

    // Two-flop synchroniser plus a history flop for start-edge detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_r <= 1'b1;
            sync2_r <= 1'b1;
            hist_r  <= 1'b1;
        end else begin
            sync1_r <= uart_rx;
            sync2_r <= sync1_r;
            hist_r  <= sync2_r;
        end
    end

    // Frame FSM: sample each bit at mid-period, counted from the start edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= IDLE;
            baud_cnt_r <= CNT_ZERO;
            bit_idx_r  <= 3'd0;
            shreg_r    <= 8'h00;
`ifdef UART_RX_PARITY_EN
            par_bit_r  <= 1'b0;
`endif
        end else begin
            case (state_r)
                IDLE: begin
                    if (hist_r && !sync2_r) begin
                        baud_cnt_r <= HALF_C;
                        state_r    <= START;
                    end
                end
                START: begin
                    if (baud_cnt_r == CNT_ZERO) begin
                        if (!sync2_r) begin
                            baud_cnt_r <= FULL_C;
                            bit_idx_r  <= 3'd0;
                            state_r    <= DATA;
                        end else begin
                            state_r <= IDLE;
                        end
                    end else begin
                        baud_cnt_r <= baud_cnt_r - CNT_ONE;
                    end
                end
                DATA: begin
                    if (baud_cnt_r == CNT_ZERO) begin
                        shreg_r    <= {sync2_r, shreg_r[7:1]};
                        baud_cnt_r <= FULL_C;
                        if (bit_idx_r == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            state_r <= PARITY;
`else
                            state_r <= STOP;
`endif
                        end else begin
                            bit_idx_r <= bit_idx_r + 3'd1;
                        end
                    end else begin
                        baud_cnt_r <= baud_cnt_r - CNT_ONE;
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (baud_cnt_r == CNT_ZERO) begin
                        par_bit_r  <= sync2_r;
                        baud_cnt_r <= FULL_C;
                        state_r    <= STOP;
                    end else begin
                        baud_cnt_r <= baud_cnt_r - CNT_ONE;
                    end
                end
`endif
                STOP: begin
                    if (baud_cnt_r == CNT_ZERO) begin
                        state_r <= IDLE;
                    end else begin
                        baud_cnt_r <= baud_cnt_r - CNT_ONE;
                    end
                end
                default: state_r <= IDLE;
            endcase
        end
    end

    // Stop-bit outcome: push the byte, or flag why it was discarded
    always_comb begin
        stop_tick_s = (state_r == STOP) && (baud_cnt_r == CNT_ZERO);
`ifdef UART_RX_PARITY_EN
        par_ok_s    = (par_bit_r == even_parity(shreg_r));
`else
        par_ok_s    = 1'b1;
`endif
        push_s      = stop_tick_s && sync2_r && par_ok_s;
        frame_set_s = stop_tick_s && !sync2_r;
        par_set_s   = stop_tick_s && !par_ok_s;
    end

    // Bus decode: pops, write-1-to-clear mask, overrun detection
    always_comb begin
        pop_s     = mmio_req && !mmio_we && (mmio_addr == RXDATA_ADDR);
        ovr_set_s = push_s && fifo_full_s && !pop_s;
        if (mmio_req && mmio_we && (mmio_addr == RXSTAT_ADDR)) begin
            clr_s = {mmio_wdata[3:1], 1'b0};
        end else begin
            clr_s = 4'h0;
        end
    end

    uart_rx_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_s),
        .pop   (pop_s),
        .din   (shreg_r),
        .full  (fifo_full_s),
        .empty (fifo_empty_s),
        .head  (fifo_head_s)
    );

    // Sticky error flags; a set in the same cycle as a clear wins
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overrun_r   <= 1'b0;
            frame_err_r <= 1'b0;
            par_err_r   <= 1'b0;
            rx_irq_r    <= 1'b0;
        end else begin
            overrun_r   <= (overrun_r   && !clr_s[STAT_OVERRUN]) || ovr_set_s;
            frame_err_r <= (frame_err_r && !clr_s[STAT_FRAME])   || frame_set_s;
            par_err_r   <= (par_err_r   && !clr_s[STAT_PARITY])  || par_set_s;
            rx_irq_r    <= !fifo_empty_s;
        end
    end

    assign rx_irq   = rx_irq_r;
    assign unused_s = ^{mmio_wdata[`XLEN-1:4], mmio_wdata[STAT_VALID]};

    // Status vector assembled by bit index
    always_comb begin
        stat_s               = 4'h0;
        stat_s[STAT_VALID]   = !fifo_empty_s;
        stat_s[STAT_OVERRUN] = overrun_r;
        stat_s[STAT_FRAME]   = frame_err_r;
        stat_s[STAT_PARITY]  = par_err_r;
    end

    // Load data mux, valid in the request cycle
    always_comb begin
        mmio_rdata = {`XLEN{1'b0}};
        if (mmio_req && !mmio_we) begin
            if ((mmio_addr == RXDATA_ADDR) && !fifo_empty_s) begin
                mmio_rdata = {{(`XLEN-8){1'b0}}, fifo_head_s};
            end else if (mmio_addr == RXSTAT_ADDR) begin
                mmio_rdata = {{(`XLEN-4){1'b0}}, stat_s};
            end else begin
                mmio_rdata = {`XLEN{1'b0}};
            end
        end else begin
            mmio_rdata = {`XLEN{1'b0}};
        end
    end

endmodule

// File: tb/tb_uart_rx_mmio.sv
// Directed self-checking bench for uart_rx_mmio (8N1, 16 clocks per bit).
`ifndef XLEN
`define XLEN 32
`endif
`ifndef ADDR_W
`define ADDR_W 32
`endif
`ifndef IO_BASE_ADDR
`define IO_BASE_ADDR 32'h1000_0000
`endif

module tb_uart_rx_mmio;

    localparam logic [`ADDR_W-1:0] RXDATA_A = `IO_BASE_ADDR + 32'h10;
    localparam logic [`ADDR_W-1:0] RXSTAT_A = `IO_BASE_ADDR + 32'h14;

    logic               clk;
    logic               rst;
    logic               uart_rx;
    logic               mmio_req;
    logic               mmio_we;
    logic [`ADDR_W-1:0] mmio_addr;
    logic [`XLEN-1:0]   mmio_wdata;
    logic [`XLEN-1:0]   mmio_rdata;
    logic               rx_irq;

    int          checks;
    int          errors;
    logic [31:0] rd;
    logic [31:0] popped;

    uart_rx_mmio #(
        .CLKS_PER_BIT (16),
        .FIFO_DEPTH   (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .uart_rx    (uart_rx),
        .mmio_req   (mmio_req),
        .mmio_we    (mmio_we),
        .mmio_addr  (mmio_addr),
        .mmio_wdata (mmio_wdata),
        .mmio_rdata (mmio_rdata),
        .rx_irq     (rx_irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    // Called one time unit after a rising edge; returns in the same phase.
    task automatic mmio_rd(input logic [`ADDR_W-1:0] a, output logic [31:0] d);
        mmio_req  = 1'b1;
        mmio_we   = 1'b0;
        mmio_addr = a;
        #1;
        d = mmio_rdata;
        @(posedge clk);
        #1;
        mmio_req = 1'b0;
    endtask

    task automatic mmio_wr(input logic [`ADDR_W-1:0] a, input logic [31:0] d);
        mmio_req   = 1'b1;
        mmio_we    = 1'b1;
        mmio_addr  = a;
        mmio_wdata = d;
        @(posedge clk);
        #1;
        mmio_req = 1'b0;
        mmio_we  = 1'b0;
    endtask

    // The push happens between the 10th and 11th edge after the stop bit
    // begins, so an optional RXDATA pop is placed in exactly that cycle.
    task automatic send_frame(input logic [7:0] b, input logic stop_v,
                              input logic pop_at_push, output logic [31:0] p);
        p = 32'h0;
        uart_rx = 1'b0;
        repeat (16) @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            repeat (16) @(posedge clk);
            #1;
        end
        uart_rx = stop_v;
        if (pop_at_push) begin
            repeat (10) @(posedge clk);
            #1;
            mmio_rd(RXDATA_A, p);
            repeat (5) @(posedge clk);
            #1;
        end else begin
            repeat (16) @(posedge clk);
            #1;
        end
        uart_rx = 1'b1;
        repeat (4) @(posedge clk);
        #1;
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        rst        = 1'b1;
        uart_rx    = 1'b1;
        mmio_req   = 1'b0;
        mmio_we    = 1'b0;
        mmio_addr  = '0;
        mmio_wdata = '0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_irq", {31'd0, rx_irq}, 32'h0);
        mmio_rd(RXSTAT_A, rd);
        chk("rst_stat", rd, 32'h0);
        mmio_rd(RXDATA_A, rd);
        chk("rst_data", rd, 32'h0);
        rst = 1'b0;
        repeat (4) @(posedge clk);
        #1;

        // Single frame
        send_frame(8'hA5, 1'b1, 1'b0, popped);
        mmio_rd(RXSTAT_A, rd);
        chk("single_stat", rd, 32'h1);
        chk("single_irq", {31'd0, rx_irq}, 32'h1);
        mmio_rd(RXDATA_A, rd);
        chk("single_data", rd, 32'h0000_00A5);
        repeat (2) @(posedge clk);
        #1;
        mmio_rd(RXSTAT_A, rd);
        chk("single_stat_after", rd, 32'h0);
        chk("single_irq_after", {31'd0, rx_irq}, 32'h0);

        // Glitch rejection
        uart_rx = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        uart_rx = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        mmio_rd(RXSTAT_A, rd);
        chk("glitch_stat", rd, 32'h0);
        chk("glitch_irq", {31'd0, rx_irq}, 32'h0);

        // Overrun
        send_frame(8'h00, 1'b1, 1'b0, popped);
        send_frame(8'h11, 1'b1, 1'b0, popped);
        send_frame(8'h22, 1'b1, 1'b0, popped);
        send_frame(8'h33, 1'b1, 1'b0, popped);
        send_frame(8'h44, 1'b1, 1'b0, popped);
        mmio_rd(RXSTAT_A, rd);
        chk("ovr_stat", rd, 32'h3);
        mmio_rd(RXDATA_A, rd);
        chk("ovr_pop0", rd, 32'h00);
        mmio_rd(RXDATA_A, rd);
        chk("ovr_pop1", rd, 32'h11);
        mmio_rd(RXDATA_A, rd);
        chk("ovr_pop2", rd, 32'h22);
        mmio_rd(RXDATA_A, rd);
        chk("ovr_pop3", rd, 32'h33);
        mmio_rd(RXDATA_A, rd);
        chk("ovr_pop_empty", rd, 32'h0);
        mmio_wr(RXSTAT_A, 32'h2);
        mmio_rd(RXSTAT_A, rd);
        chk("ovr_clear", rd, 32'h0);

        // Frame error, then recovery
        send_frame(8'h55, 1'b0, 1'b0, popped);
        mmio_rd(RXSTAT_A, rd);
        chk("ferr_stat", rd, 32'h4);
        send_frame(8'h66, 1'b1, 1'b0, popped);
        mmio_rd(RXSTAT_A, rd);
        chk("ferr_next_stat", rd, 32'h5);
        mmio_rd(RXDATA_A, rd);
        chk("ferr_next_data", rd, 32'h66);
        mmio_wr(RXSTAT_A, 32'h4);
        mmio_rd(RXSTAT_A, rd);
        chk("ferr_clear", rd, 32'h0);

        // Full FIFO with a pop in the push cycle
        send_frame(8'h00, 1'b1, 1'b0, popped);
        send_frame(8'h11, 1'b1, 1'b0, popped);
        send_frame(8'h22, 1'b1, 1'b0, popped);
        send_frame(8'h33, 1'b1, 1'b0, popped);
        send_frame(8'h77, 1'b1, 1'b1, popped);
        chk("conc_popped", popped, 32'h00);
        mmio_rd(RXSTAT_A, rd);
        chk("conc_stat", rd, 32'h1);
        mmio_rd(RXDATA_A, rd);
        chk("conc_pop0", rd, 32'h11);
        mmio_rd(RXDATA_A, rd);
        chk("conc_pop1", rd, 32'h22);
        mmio_rd(RXDATA_A, rd);
        chk("conc_pop2", rd, 32'h33);
        mmio_rd(RXDATA_A, rd);
        chk("conc_pop3", rd, 32'h77);
        mmio_rd(RXSTAT_A, rd);
        chk("conc_stat_end", rd, 32'h0);

        // Asynchronous reset in the middle of a frame
        send_frame(8'h5A, 1'b1, 1'b0, popped);
        repeat (2) @(posedge clk);
        #1;
        chk("mid_irq_before", {31'd0, rx_irq}, 32'h1);
        uart_rx = 1'b0;
        repeat (16) @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            uart_rx = (i % 2 == 0) ? 1'b1 : 1'b0;
            repeat (16) @(posedge clk);
            #1;
        end
        rst = 1'b1;
        #1;
        chk("mid_irq_rst", {31'd0, rx_irq}, 32'h0);
        mmio_rd(RXSTAT_A, rd);
        chk("mid_stat_rst", rd, 32'h0);
        mmio_rd(RXDATA_A, rd);
        chk("mid_data_rst", rd, 32'h0);
        uart_rx = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        send_frame(8'h3C, 1'b1, 1'b0, popped);
        mmio_rd(RXSTAT_A, rd);
        chk("post_rst_stat", rd, 32'h1);
        mmio_rd(RXDATA_A, rd);
        chk("post_rst_data", rd, 32'h3C);
        mmio_rd(RXSTAT_A, rd);
        chk("post_rst_stat_end", rd, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_rx_mmio.md
Name: uart_rx_mmio

Overview:
- Memory-mapped UART receiver. It is the receive-side counterpart of the existing MMIO UART transmitter on the SoC I/O bus.
- Deserialises 8N1 frames from the `uart_rx` pin into a small RX FIFO.
- The CPU polls a status register and pops bytes with loads; stores to status clear sticky error flags.
- Sits beside the TX peripheral inside the I/O block and decodes its own register window.

Parameters:
- CLKS_PER_BIT, 434: clk cycles per bit period (50 MHz / 115200 baud). Must be ≥ 8.
- FIFO_DEPTH, 4: RX FIFO entries. Power of two, ≥ 2.
- BASE_ADDR, `IO_BASE_ADDR + 32'h10: byte address of RXDATA. RXSTAT is at BASE_ADDR+4.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- uart_rx  in  1  serial input, idle high, asynchronous to clk
- mmio_req  in  1  bus access strobe, one cycle per access
- mmio_we  in  1  1 = store, 0 = load
- mmio_addr  in  `ADDR_W  byte address
- mmio_wdata  in  `XLEN  store data
- mmio_rdata  out  `XLEN  load data, combinational, valid in the mmio_req cycle
- rx_irq  out  1  level interrupt, high while the FIFO is non-empty

Behaviour:
- Reset (asynchronous, rst=1):
  - FSM=IDLE; counters 0; FIFO empty; sticky flags 0; synchroniser flops 1.
  - Outputs: rx_irq=0, mmio_rdata=0.
- Input path: two-flop synchroniser on uart_rx, then one history flop for edge detection.
- FSM states and transitions:
  - IDLE: a falling edge on the synced input loads baud_cnt = CLKS_PER_BIT/2 - 1, go START.
  - START: at baud_cnt==0, re-sample the line.
    - Low: baud_cnt = CLKS_PER_BIT-1, bit_idx=0, go DATA.
    - High: glitch; go IDLE, nothing recorded.
  - DATA: at each baud_cnt==0, shift the sample into shreg LSB-first and reload baud_cnt.
    - After bit_idx==7, go STOP.
  - STOP: at baud_cnt==0, sample the line.
    - 1: push shreg into the FIFO.
    - 0: set frame_err, discard the byte.
    - Either way, go IDLE the same cycle.
- A new start edge is recognised the cycle after returning to IDLE.
- Latency: the byte is visible in the FIFO 1 cycle after the mid-stop-bit sample. Frame start to push is about 9.5 bit times + 3 cycles.
- Register map (word accesses only; other addresses not decoded, rdata=0):
  - RXDATA (BASE_ADDR), load:
    - rdata = {24'h0, FIFO head}; pops in the same cycle.
    - Empty FIFO: rdata=0, no pop, no error.
    - Stores are ignored.
  - RXSTAT (BASE_ADDR+4), load: rdata = {28'h0, par_err, frame_err, overrun, rx_valid}, where rx_valid = !empty.
  - RXSTAT, store: write-1-to-clear on bits [3:1]. Bit 0 is read-only.
- Overrun: a push while the FIFO is full drops the new byte and sets overrun. The FIFO contents are unchanged.
- Simultaneous pop and push when full: pop and push both take effect, count is unchanged, no overrun.
- Simultaneous W1C and set of the same flag in one cycle: set wins.
- Pointers wrap modulo FIFO_DEPTH. A count of log2(FIFO_DEPTH)+1 bits distinguishes full from empty.
- rx_irq = !empty, registered off the FIFO count. No other outputs are registered.
- Reset mid-frame: the partial frame is lost and the FSM restarts in IDLE after rst falls.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - Frame is 8E1, with a PARITY state between DATA and STOP.
  - The received parity bit is compared with the XOR of the data bits (even parity).
  - On mismatch, par_err (RXSTAT bit 3) is set and the byte is discarded at STOP.
- Undefined: the PARITY state is absent, 8N1 frames only, and bit 3 reads 0.

Decomposition:
- Package uart_pkg holds:
  - the FSM state enum (IDLE, START, DATA, PARITY, STOP);
  - the register offsets RXDATA_OFF=0 and RXSTAT_OFF=4;
  - the status bit indices.
- Sub-module uart_rx_fifo: synchronous FIFO parameterised by width and depth.
  - Inputs: push, pop. Outputs: full, empty, head.
  - Implements the simultaneous pop/push-when-full rule.

Test Plan (CLKS_PER_BIT=16, FIFO_DEPTH=4):
- Single frame: drive 0xA5 as 8N1 -> RXSTAT reads 0x1, rx_irq=1. RXDATA load returns 0x000000A5, then RXSTAT reads 0x0 and rx_irq=0.
- Glitch rejection: a 4-cycle low pulse on an idle line -> no push, FSM back in IDLE, RXSTAT=0x0.
- Overrun: send 0x00, 0x11, 0x22, 0x33, 0x44 with no reads.
  - RXSTAT reads 0x3.
  - Four RXDATA pops return 0x00, 0x11, 0x22, 0x33.
  - Store 0x2 to RXSTAT -> RXSTAT reads 0x0.
- Frame error: send 0x55 with the stop bit held 0 -> RXSTAT reads 0x4, FIFO empty. A following valid 0x66 is received correctly.
- Full plus concurrent pop: pop in exactly the cycle a 5th byte 0x77 is pushed -> no overrun. Subsequent pops yield 0x11, 0x22, 0x33, 0x77.
- Async reset mid-frame: assert rst after 4 data bits -> all state and outputs are 0 immediately. The next full 0x3C frame is received as 0x3C.
